// File: rtl/dequeue_issuer.sv
// Dequeue issuer: tags scheduler requests, turns queue_manager responses into fetch descriptors,
// and issues commits on fetch completion. Request/descriptor/commit outputs are registered (1 cycle).
module dequeue_issuer #(
  parameter int QUEUE_INDEX_WIDTH = 8,
  parameter int REQ_TAG_WIDTH     = 3,
  parameter int OP_TAG_WIDTH      = 8,
  parameter int QUEUE_PTR_WIDTH   = 16,
  parameter int ADDR_WIDTH        = 64
) (
  input  logic                         clk,
  input  logic                         rst,

  input  logic [QUEUE_INDEX_WIDTH-1:0] s_axis_sched_queue,
  input  logic                         s_axis_sched_valid,
  output logic                         s_axis_sched_ready,

  output logic [QUEUE_INDEX_WIDTH-1:0] m_axis_dequeue_req_queue,
  output logic [REQ_TAG_WIDTH-1:0]     m_axis_dequeue_req_tag,
  output logic                         m_axis_dequeue_req_valid,
  input  logic                         m_axis_dequeue_req_ready,

  input  logic [QUEUE_INDEX_WIDTH-1:0] s_axis_dequeue_resp_queue,
  input  logic [QUEUE_PTR_WIDTH-1:0]   s_axis_dequeue_resp_ptr,
  input  logic [ADDR_WIDTH-1:0]        s_axis_dequeue_resp_addr,
  input  logic [REQ_TAG_WIDTH-1:0]     s_axis_dequeue_resp_tag,
  input  logic [OP_TAG_WIDTH-1:0]      s_axis_dequeue_resp_op_tag,
  input  logic                         s_axis_dequeue_resp_empty,
  input  logic                         s_axis_dequeue_resp_error,
  input  logic                         s_axis_dequeue_resp_valid,
  output logic                         s_axis_dequeue_resp_ready,

  output logic [QUEUE_INDEX_WIDTH-1:0] m_axis_desc_queue,
  output logic [QUEUE_PTR_WIDTH-1:0]   m_axis_desc_ptr,
  output logic [ADDR_WIDTH-1:0]        m_axis_desc_addr,
  output logic [REQ_TAG_WIDTH-1:0]     m_axis_desc_tag,
  output logic                         m_axis_desc_valid,
  input  logic                         m_axis_desc_ready,

  input  logic [REQ_TAG_WIDTH-1:0]     s_axis_desc_done_tag,
  input  logic                         s_axis_desc_done_valid,
  output logic                         s_axis_desc_done_ready,

  output logic [OP_TAG_WIDTH-1:0]      m_axis_dequeue_commit_op_tag,
  output logic                         m_axis_dequeue_commit_valid,
  input  logic                         m_axis_dequeue_commit_ready,

  output logic [REQ_TAG_WIDTH:0]       outstanding,
  output logic                         stat_empty,
  output logic                         stat_error,
  output logic                         stat_bad_tag
);

  localparam int NSLOT = 1 << REQ_TAG_WIDTH;

  typedef enum logic [1:0] {
    SLOT_FREE      = 2'd0,
    SLOT_WAIT_RESP = 2'd1,
    SLOT_WAIT_DONE = 2'd2
  } slot_state_e;

  slot_state_e               slot_q   [NSLOT];
  slot_state_e               slot_d   [NSLOT];
  logic [OP_TAG_WIDTH-1:0]   op_tag_q [NSLOT];
  logic [OP_TAG_WIDTH-1:0]   op_tag_d [NSLOT];

  logic [QUEUE_INDEX_WIDTH-1:0] req_queue_q, req_queue_d;
  logic [REQ_TAG_WIDTH-1:0]     req_tag_q, req_tag_d;
  logic                         req_valid_q, req_valid_d;

  logic [QUEUE_INDEX_WIDTH-1:0] desc_queue_q, desc_queue_d;
  logic [QUEUE_PTR_WIDTH-1:0]   desc_ptr_q, desc_ptr_d;
  logic [ADDR_WIDTH-1:0]        desc_addr_q, desc_addr_d;
  logic [REQ_TAG_WIDTH-1:0]     desc_tag_q, desc_tag_d;
  logic                         desc_valid_q, desc_valid_d;

  logic [OP_TAG_WIDTH-1:0]      commit_op_tag_q, commit_op_tag_d;
  logic                         commit_valid_q, commit_valid_d;

  logic [REQ_TAG_WIDTH:0]       outstanding_q, outstanding_d;
  logic                         stat_empty_q, stat_empty_d;
  logic                         stat_error_q, stat_error_d;
  logic                         stat_bad_tag_q, stat_bad_tag_d;

  logic                         any_free;
  logic [REQ_TAG_WIDTH-1:0]     alloc_tag;
  logic                         sched_fire, resp_fire, done_fire;

  // Lowest-index free slot, chosen from start-of-cycle state only.
  always_comb begin
    any_free  = 1'b0;
    alloc_tag = '0;
    for (int i = NSLOT - 1; i >= 0; i--) begin
      if (slot_q[i] == SLOT_FREE) begin
        any_free  = 1'b1;
        alloc_tag = REQ_TAG_WIDTH'(i);
      end
    end
  end

  assign s_axis_sched_ready        = any_free && (!req_valid_q || m_axis_dequeue_req_ready);
  assign s_axis_dequeue_resp_ready = !desc_valid_q || m_axis_desc_ready;
  assign s_axis_desc_done_ready    = !commit_valid_q || m_axis_dequeue_commit_ready;

  assign sched_fire = s_axis_sched_valid && s_axis_sched_ready;
  assign resp_fire  = s_axis_dequeue_resp_valid && s_axis_dequeue_resp_ready;
  assign done_fire  = s_axis_desc_done_valid && s_axis_desc_done_ready;

  always_comb begin
    slot_d          = slot_q;
    op_tag_d        = op_tag_q;
    req_queue_d     = req_queue_q;
    req_tag_d       = req_tag_q;
    req_valid_d     = req_valid_q;
    desc_queue_d    = desc_queue_q;
    desc_ptr_d      = desc_ptr_q;
    desc_addr_d     = desc_addr_q;
    desc_tag_d      = desc_tag_q;
    desc_valid_d    = desc_valid_q;
    commit_op_tag_d = commit_op_tag_q;
    commit_valid_d  = commit_valid_q;
    stat_empty_d    = 1'b0;
    stat_error_d    = 1'b0;
    stat_bad_tag_d  = 1'b0;
    outstanding_d   = '0;

    if (m_axis_dequeue_req_ready) req_valid_d = 1'b0;
    if (sched_fire) begin
      req_valid_d       = 1'b1;
      req_queue_d       = s_axis_sched_queue;
      req_tag_d         = alloc_tag;
      slot_d[alloc_tag] = SLOT_WAIT_RESP;
    end

    if (m_axis_desc_ready) desc_valid_d = 1'b0;
    if (resp_fire) begin
      if (slot_q[s_axis_dequeue_resp_tag] != SLOT_WAIT_RESP) begin
        stat_bad_tag_d = 1'b1;
      end else if (s_axis_dequeue_resp_error) begin
        slot_d[s_axis_dequeue_resp_tag] = SLOT_FREE;
        stat_error_d                    = 1'b1;
      end else if (s_axis_dequeue_resp_empty) begin
        slot_d[s_axis_dequeue_resp_tag] = SLOT_FREE;
        stat_empty_d                    = 1'b1;
      end else begin
        slot_d[s_axis_dequeue_resp_tag]   = SLOT_WAIT_DONE;
        op_tag_d[s_axis_dequeue_resp_tag] = s_axis_dequeue_resp_op_tag;
        desc_queue_d = s_axis_dequeue_resp_queue;
        desc_ptr_d   = s_axis_dequeue_resp_ptr;
        desc_addr_d  = s_axis_dequeue_resp_addr;
        desc_tag_d   = s_axis_dequeue_resp_tag;
        desc_valid_d = 1'b1;
      end
    end

    if (m_axis_dequeue_commit_ready) commit_valid_d = 1'b0;
    if (done_fire) begin
      if (slot_q[s_axis_desc_done_tag] == SLOT_WAIT_DONE) begin
        commit_op_tag_d              = op_tag_q[s_axis_desc_done_tag];
        commit_valid_d               = 1'b1;
        slot_d[s_axis_desc_done_tag] = SLOT_FREE;
      end else begin
        stat_bad_tag_d = 1'b1;
      end
    end

    for (int i = 0; i < NSLOT; i++) begin
      if (slot_d[i] != SLOT_FREE) outstanding_d = outstanding_d + (REQ_TAG_WIDTH + 1)'(1);
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      for (int i = 0; i < NSLOT; i++) begin
        slot_q[i]   <= SLOT_FREE;
        op_tag_q[i] <= '0;
      end
      req_queue_q     <= '0;
      req_tag_q       <= '0;
      req_valid_q     <= 1'b0;
      desc_queue_q    <= '0;
      desc_ptr_q      <= '0;
      desc_addr_q     <= '0;
      desc_tag_q      <= '0;
      desc_valid_q    <= 1'b0;
      commit_op_tag_q <= '0;
      commit_valid_q  <= 1'b0;
      outstanding_q   <= '0;
      stat_empty_q    <= 1'b0;
      stat_error_q    <= 1'b0;
      stat_bad_tag_q  <= 1'b0;
    end else begin
      slot_q          <= slot_d;
      op_tag_q        <= op_tag_d;
      req_queue_q     <= req_queue_d;
      req_tag_q       <= req_tag_d;
      req_valid_q     <= req_valid_d;
      desc_queue_q    <= desc_queue_d;
      desc_ptr_q      <= desc_ptr_d;
      desc_addr_q     <= desc_addr_d;
      desc_tag_q      <= desc_tag_d;
      desc_valid_q    <= desc_valid_d;
      commit_op_tag_q <= commit_op_tag_d;
      commit_valid_q  <= commit_valid_d;
      outstanding_q   <= outstanding_d;
      stat_empty_q    <= stat_empty_d;
      stat_error_q    <= stat_error_d;
      stat_bad_tag_q  <= stat_bad_tag_d;
    end
  end

  assign m_axis_dequeue_req_queue     = req_queue_q;
  assign m_axis_dequeue_req_tag       = req_tag_q;
  assign m_axis_dequeue_req_valid     = req_valid_q;
  assign m_axis_desc_queue            = desc_queue_q;
  assign m_axis_desc_ptr              = desc_ptr_q;
  assign m_axis_desc_addr             = desc_addr_q;
  assign m_axis_desc_tag              = desc_tag_q;
  assign m_axis_desc_valid            = desc_valid_q;
  assign m_axis_dequeue_commit_op_tag = commit_op_tag_q;
  assign m_axis_dequeue_commit_valid  = commit_valid_q;
  assign outstanding                  = outstanding_q;
  assign stat_empty                   = stat_empty_q;
  assign stat_error                   = stat_error_q;
  assign stat_bad_tag                 = stat_bad_tag_q;

endmodule
